// File: rtl/whirlpool_iter_core.sv
// Iterative Whirlpool Miyaguchi-Preneel compression; one shared round function alternates key-schedule and data rounds.
// Latency: out_valid rises 2*ROUNDS edges after the capture edge; one job in flight.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; abort drops the job.
// Build option: define WHIRLPOOL_TARGET_CMP_EN to add the target input and the out_match output.
module whirlpool_iter_core #(
    parameter int ROUNDS = 10,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_state,
    input  logic [511:0]     in_block,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [511:0]     out_hash,
    output logic [TAG_W-1:0] out_tag,
`ifdef WHIRLPOOL_TARGET_CMP_EN
    input  logic [63:0]      target,
    output logic             out_match,
`endif
    output logic             busy
);

    generate
        if (ROUNDS < 1 || ROUNDS > 10) begin : g_bad_rounds
            $error("whirlpool_iter_core: ROUNDS must be in 1..10");
        end
        if (TAG_W < 1 || TAG_W > 32) begin : g_bad_tag_w
            $error("whirlpool_iter_core: TAG_W must be in 1..32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, KEY, DATA, DONE} fsm_t;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    // 4-bit mini-boxes the S-box is built from (E, E inverse, R); entry x sits at nibble x from the left
    localparam logic [63:0] E_TAB  = 64'h1B9C_D6F3_E874_A250;
    localparam logic [63:0] EI_TAB = 64'hF0D7_BE5A_92C1_3486;
    localparam logic [63:0] R_TAB  = 64'h7CBD_E49F_638A_2510;

    function automatic logic [3:0] nib(input logic [63:0] tab, input logic [3:0] idx);
        logic [63:0] t;
        t = tab << {idx, 2'b00};
        return t[63:60];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] a, b, r;
        a = nib(E_TAB, x[7:4]);
        b = nib(EI_TAB, x[3:0]);
        r = nib(R_TAB, a ^ b);
        return {nib(E_TAB, a ^ r), nib(EI_TAB, b ^ r)};
    endfunction

    // multiply by x in GF(2^8) with reduction polynomial x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    // one Whirlpool round: S-box, column rotation, circulant row mix (1,1,4,1,8,5,2,9), key add
    function automatic logic [511:0] process_round(input logic [511:0] a, input logic [511:0] k);
        logic [7:0]   p [8][8];
        logic [7:0]   v1, v2, v4, v8, acc;
        logic [2:0]   ci, ri;
        logic [511:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                ri = 3'(i + j);
                p[ri][j] = sbox(a[511 - 64*i - 8*j -: 8]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = 8'h00;
                for (int c = 0; c < 8; c++) begin
                    v1 = p[i][c];
                    v2 = xt(v1);
                    v4 = xt(v2);
                    v8 = xt(v4);
                    ci = 3'(j - c);
                    case (ci)
                        3'd0: acc = acc ^ v1;
                        3'd1: acc = acc ^ v1;
                        3'd2: acc = acc ^ v4;
                        3'd3: acc = acc ^ v1;
                        3'd4: acc = acc ^ v8;
                        3'd5: acc = acc ^ v4 ^ v1;
                        3'd6: acc = acc ^ v2;
                        3'd7: acc = acc ^ v8 ^ v1;
                    endcase
                end
                res[511 - 64*i - 8*j -: 8] = acc ^ k[511 - 64*i - 8*j -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [63:0] rc(input logic [3:0] r);
        case (r)
            4'd0:    rc = 64'h1823C6E887B8014F;
            4'd1:    rc = 64'h36A6D2F5796F9152;
            4'd2:    rc = 64'h60BC9B8EA30C7B35;
            4'd3:    rc = 64'h1DE0D7C22E4BFE57;
            4'd4:    rc = 64'h157737E59FF04ADA;
            4'd5:    rc = 64'h58C9290AB1A06B85;
            4'd6:    rc = 64'hBD5D10F4CB3E0567;
            4'd7:    rc = 64'hE427418BA77D95D8;
            4'd8:    rc = 64'hFBEE7C66DD17479E;
            4'd9:    rc = 64'hCA2DBF07AD5A8333;
            default: rc = 64'h0;
        endcase
    endfunction

    fsm_t             fsm_q, fsm_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [511:0]     k_q, k_d;
    logic [511:0]     d_q, d_d;
    logic [511:0]     ff_q, ff_d;       // state ^ block, the feed-forward term
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [511:0]     out_hash_q, out_hash_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [511:0]     rnd_in, rnd_key, rnd_out;
`ifdef WHIRLPOOL_TARGET_CMP_EN
    logic [63:0]      target_q, target_d;
    logic             match_q, match_d;
`endif

    // shared round function operand mux: key schedule in KEY, data path otherwise
    always_comb begin
        rnd_in  = d_q;
        rnd_key = k_q;
        if (fsm_q == KEY) begin
            rnd_in  = k_q;
            rnd_key = {rc(rnd_q), 448'd0};
        end
    end

    assign rnd_out = process_round(rnd_in, rnd_key);

    // next-state and datapath update
    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        k_d         = k_q;
        d_d         = d_q;
        ff_d        = ff_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        out_hash_d  = out_hash_q;
        out_tag_d   = out_tag_q;
`ifdef WHIRLPOOL_TARGET_CMP_EN
        target_d    = target_q;
        match_d     = abort ? 1'b0 : match_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    k_d   = in_state;
                    d_d   = in_state ^ in_block;
                    ff_d  = in_state ^ in_block;
                    tag_d = in_tag;
                    rnd_d = 4'd0;
`ifdef WHIRLPOOL_TARGET_CMP_EN
                    target_d = target;
`endif
                    fsm_d = KEY;
                end
            end
            KEY: begin
                if (abort) begin
                    fsm_d = IDLE;
                end else begin
                    k_d   = rnd_out;
                    fsm_d = DATA;
                end
            end
            DATA: begin
                if (abort) begin
                    fsm_d = IDLE;
                end else begin
                    d_d = rnd_out;
                    if (rnd_q == LAST_RND) begin
                        out_hash_d  = ff_q ^ rnd_out;
                        out_tag_d   = tag_q;
                        out_valid_d = 1'b1;
`ifdef WHIRLPOOL_TARGET_CMP_EN
                        match_d     = ((ff_q[63:0] ^ rnd_out[63:0]) <= target_q);
`endif
                        fsm_d       = DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                        fsm_d = KEY;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd0;
            k_q         <= '0;
            d_q         <= '0;
            ff_q        <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_hash_q  <= '0;
            out_tag_q   <= '0;
`ifdef WHIRLPOOL_TARGET_CMP_EN
            target_q    <= '0;
            match_q     <= 1'b0;
`endif
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            k_q         <= k_d;
            d_q         <= d_d;
            ff_q        <= ff_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_hash_q  <= out_hash_d;
            out_tag_q   <= out_tag_d;
`ifdef WHIRLPOOL_TARGET_CMP_EN
            target_q    <= target_d;
            match_q     <= match_d;
`endif
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_hash  = out_hash_q;
    assign out_tag   = out_tag_q;
`ifdef WHIRLPOOL_TARGET_CMP_EN
    assign out_match = match_q;
`endif

endmodule

// File: tb/tb_whirlpool_iter_core.sv
// Bench for whirlpool_iter_core: a 10-round instance and a 1-round instance checked
// against a matrix-level Whirlpool model and the published empty-message digest.
module tb_whirlpool_iter_core;

    localparam logic [511:0] EMPTY_BLK  = {8'h80, 504'd0};
    localparam logic [511:0] EMPTY_HASH = 512'h19FA61D75522A466_9B44E39C1D2E1726_C530232130D407F8_9AFEE0964997F7A7_3E83BE698B288FEB_CF88E3E03C4F0757_EA8964E59B63D937_08B138CC42A66EB3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sbox_tab [256];

    // 10-round instance
    logic         in_valid_a, in_ready_a, abort_a, out_valid_a, out_ready_a, busy_a;
    logic [511:0] in_state_a, in_block_a, out_hash_a;
    logic [7:0]   in_tag_a, out_tag_a;
    // 1-round instance
    logic         in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b, busy_b;
    logic [511:0] in_state_b, in_block_b, out_hash_b;
    logic [7:0]   in_tag_b, out_tag_b;
`ifdef WHIRLPOOL_TARGET_CMP_EN
    logic [63:0]  target_a, target_b;
    logic         out_match_a, out_match_b;
`endif

    whirlpool_iter_core #(.ROUNDS(10), .TAG_W(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_state(in_state_a), .in_block(in_block_a), .in_tag(in_tag_a),
        .abort(abort_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_hash(out_hash_a), .out_tag(out_tag_a),
`ifdef WHIRLPOOL_TARGET_CMP_EN
        .target(target_a), .out_match(out_match_a),
`endif
        .busy(busy_a)
    );

    whirlpool_iter_core #(.ROUNDS(1), .TAG_W(8)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_state(in_state_b), .in_block(in_block_b), .in_tag(in_tag_b),
        .abort(abort_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_hash(out_hash_b), .out_tag(out_tag_b),
`ifdef WHIRLPOOL_TARGET_CMP_EN
        .target(target_b), .out_match(out_match_b),
`endif
        .busy(busy_b)
    );

    // ---------------- reference model ----------------
    task automatic build_sbox();
        logic [3:0] e [16];
        logic [3:0] r [16];
        logic [3:0] ei [16];
        logic [3:0] u, l, a, b, t;
        e = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3, 4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
        r = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF, 4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};
        for (int x = 0; x < 16; x++) ei[e[x]] = 4'(x);
        for (int x = 0; x < 256; x++) begin
            u = 4'(x >> 4);
            l = 4'(x);
            a = e[u];
            b = ei[l];
            t = r[a ^ b];
            sbox_tab[x] = {e[a ^ t], ei[b ^ t]};
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [511:0] ref_round(input logic [511:0] a, input logic [511:0] k);
        logic [7:0] m [8][8];
        logic [7:0] s [8][8];
        logic [7:0] cc [8];
        logic [7:0] t;
        logic [511:0] res;
        cc = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m[i][j] = sbox_tab[a[511 - 8*(8*i + j) -: 8]];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                s[i][j] = m[(i - j + 8) % 8][j];
        res = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                t = 8'h00;
                for (int c = 0; c < 8; c++) t = t ^ gmul(s[i][c], cc[(j - c + 8) % 8]);
                res[511 - 8*(8*i + j) -: 8] = t ^ k[511 - 8*(8*i + j) -: 8];
            end
        return res;
    endfunction

    function automatic logic [511:0] ref_compress(input logic [511:0] h, input logic [511:0] m, input int rounds);
        logic [511:0] kk, dd, rck;
        kk = h;
        dd = m ^ h;
        for (int r = 0; r < rounds; r++) begin
            rck = '0;
            for (int j = 0; j < 8; j++) rck[511 - 8*j -: 8] = sbox_tab[8*r + j];
            kk = ref_round(kk, rck);
            dd = ref_round(dd, kk);
        end
        return dd ^ h ^ m;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit_a(input logic [511:0] s, input logic [511:0] b, input logic [7:0] t);
        int n = 0;
        while (!in_ready_a && n < 100) begin tick(); n++; end
        checks++;
        if (in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL submit_a_ready: in_ready=%0b required 1", in_ready_a);
        end
        in_state_a = s; in_block_a = b; in_tag_a = t; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0; in_state_a = rand512(); in_block_a = rand512(); in_tag_a = 8'($urandom);
    endtask

    task automatic submit_b(input logic [511:0] s, input logic [511:0] b, input logic [7:0] t);
        int n = 0;
        while (!in_ready_b && n < 100) begin tick(); n++; end
        checks++;
        if (in_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL submit_b_ready: in_ready=%0b required 1", in_ready_b);
        end
        in_state_b = s; in_block_b = b; in_tag_b = t; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0; in_state_b = rand512(); in_block_b = rand512(); in_tag_b = 8'($urandom);
    endtask

    task automatic wait_valid_a(output int lat);
        lat = 0;
        do begin tick(); lat++; end while (!out_valid_a && lat < 200);
    endtask

    task automatic wait_valid_b(output int lat);
        lat = 0;
        do begin tick(); lat++; end while (!out_valid_b && lat < 200);
    endtask

    task automatic drain_a();
        out_ready_a = 1'b1; tick(); out_ready_a = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        tick();
        checks++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl_a: out_valid=%0b busy=%0b in_ready=%0b required 0 0 1", out_valid_a, busy_a, in_ready_a);
        end
        checks++;
        if (out_hash_a !== 512'd0 || out_tag_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_data_a: out_hash=%h out_tag=%h required 0 0", out_hash_a, out_tag_a);
        end
        checks++;
        if (out_valid_b !== 1'b0 || busy_b !== 1'b0 || in_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl_b: out_valid=%0b busy=%0b in_ready=%0b required 0 0 1", out_valid_b, busy_b, in_ready_b);
        end
`ifdef WHIRLPOOL_TARGET_CMP_EN
        checks++;
        if (out_match_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_match: out_match=%0b required 0", out_match_a);
        end
`endif
    endtask

    task automatic test_empty_vector();
        int lat;
        logic [511:0] model;
        model = ref_compress(512'd0, EMPTY_BLK, 10);
        checks++;
        if (model !== EMPTY_HASH) begin
            failures++;
            $display("FAIL model_kat: model=%h required %h", model, EMPTY_HASH);
        end
        submit_a(512'd0, EMPTY_BLK, 8'h5A);
        wait_valid_a(lat);
        checks++;
        if (lat !== 20) begin failures++; $display("FAIL empty_latency: got %0d edges required 20", lat); end
        checks++;
        if (out_hash_a !== EMPTY_HASH) begin failures++; $display("FAIL empty_hash: got %h required %h", out_hash_a, EMPTY_HASH); end
        checks++;
        if (out_tag_a !== 8'h5A) begin failures++; $display("FAIL empty_tag: got %h required 5a", out_tag_a); end
        drain_a();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [511:0] s, b, exp_h;
        logic [7:0] t;
        s = rand512(); b = rand512(); t = 8'($urandom);
        exp_h = ref_compress(s, b, 10);
        submit_a(s, b, t);
        wait_valid_a(lat);
        for (int c = 0; c < 50; c++) begin
            in_valid_a = 1'b1;
            checks++;
            if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || out_hash_a !== exp_h || out_tag_a !== t) begin
                failures++;
                $display("FAIL bp_hold cyc %0d: valid=%0b in_ready=%0b tag=%h hash=%h required 1 0 %h %h", c, out_valid_a, in_ready_a, out_tag_a, out_hash_a, t, exp_h);
            end
            tick();
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b busy=%0b required 1 0 0", in_ready_a, out_valid_a, busy_a);
        end
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        submit_a(rand512(), rand512(), 8'($urandom));
        repeat (6) tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_mid: in_ready=%0b out_valid=%0b busy=%0b required 1 0 0", in_ready_a, out_valid_a, busy_a);
        end
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin tick(); if (out_valid_a) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_result: out_valid seen=%0b required 0", seen); end
        submit_a(512'd0, EMPTY_BLK, 8'h5A);
        wait_valid_a(lat);
        checks++;
        if (lat !== 20 || out_hash_a !== EMPTY_HASH) begin
            failures++;
            $display("FAIL abort_then_job: latency=%0d hash=%h required 20 %h", lat, out_hash_a, EMPTY_HASH);
        end
        drain_a();
    endtask

    task automatic test_abort_idle();
        in_valid_a = 1'b1; abort_a = 1'b1;
        tick();
        in_valid_a = 1'b0; abort_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle: busy=%0b in_ready=%0b required 0 1", busy_a, in_ready_a);
        end
    endtask

    task automatic test_abort_done();
        int lat;
        submit_a(rand512(), rand512(), 8'($urandom));
        wait_valid_a(lat);
        out_ready_a = 1'b1; abort_a = 1'b1;
        tick();
        out_ready_a = 1'b0; abort_a = 1'b0;
        checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL abort_done: out_valid=%0b in_ready=%0b required 0 1", out_valid_a, in_ready_a);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        submit_a(rand512(), rand512(), 8'($urandom));
        repeat (3) tick();
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL arst_pre_busy: busy=%0b required 1", busy_a); end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || out_hash_a !== 512'd0 || out_tag_a !== 8'd0) begin
            failures++;
            $display("FAIL arst_clear: valid=%0b busy=%0b tag=%h hash=%h required 0 0 0 0", out_valid_a, busy_a, out_tag_a, out_hash_a);
        end
        #2 rst = 1'b1;
        tick();
        checks++;
        if (in_ready_a !== 1'b1) begin failures++; $display("FAIL arst_ready: in_ready=%0b required 1", in_ready_a); end
        submit_a(512'd0, EMPTY_BLK, 8'hC3);
        wait_valid_a(lat);
        checks++;
        if (lat !== 20 || out_hash_a !== EMPTY_HASH || out_tag_a !== 8'hC3) begin
            failures++;
            $display("FAIL arst_fresh_job: latency=%0d tag=%h hash=%h required 20 c3 %h", lat, out_tag_a, out_hash_a, EMPTY_HASH);
        end
        drain_a();
    endtask

    task automatic test_rounds1();
        int lat;
        logic [511:0] s, b, exp_h;
        logic [7:0] t;
        for (int n = 0; n < 6; n++) begin
            s = rand512(); b = rand512(); t = 8'($urandom);
            exp_h = ref_compress(s, b, 1);
            submit_b(s, b, t);
            wait_valid_b(lat);
            checks++;
            if (lat !== 2) begin failures++; $display("FAIL r1_latency job %0d: got %0d required 2", n, lat); end
            checks++;
            if (out_hash_b !== exp_h || out_tag_b !== t) begin
                failures++;
                $display("FAIL r1_hash job %0d: tag=%h hash=%h required %h %h", n, out_tag_b, out_hash_b, t, exp_h);
            end
            out_ready_b = 1'b1; tick(); out_ready_b = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp_h [$];
        logic [7:0]   exp_t [$];
        int           cap [$];
        logic [511:0] s, b, eh;
        logic [7:0]   t, et;
        int nres = 0;
        out_ready_b = 1'b1;
        in_valid_b  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            s = rand512(); b = rand512(); t = 8'($urandom);
            in_state_b = s; in_block_b = b; in_tag_b = t;
            if (out_valid_b) begin
                checks++;
                if (exp_h.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra cyc %0d: result with no job pending, hash=%h", cyc, out_hash_b);
                end else begin
                    eh = exp_h.pop_front();
                    et = exp_t.pop_front();
                    nres++;
                    if (out_hash_b !== eh || out_tag_b !== et) begin
                        failures++;
                        $display("FAIL b2b_hash cyc %0d: tag=%h hash=%h required %h %h", cyc, out_tag_b, out_hash_b, et, eh);
                    end
                end
            end
            if (in_ready_b) begin
                exp_h.push_back(ref_compress(s, b, 1));
                exp_t.push_back(t);
                cap.push_back(cyc);
            end
            tick();
        end
        in_valid_b = 1'b0;
        repeat (4) tick();
        out_ready_b = 1'b0;
        checks++;
        if (cap.size() < 9 || nres < 9) begin
            failures++;
            $display("FAIL b2b_count: captures=%0d results=%0d required at least 9 each", cap.size(), nres);
        end
        for (int i = 1; i < cap.size(); i++) begin
            checks++;
            if (cap[i] - cap[i-1] !== 4) begin
                failures++;
                $display("FAIL b2b_spacing %0d: got %0d cycles required 4", i, cap[i] - cap[i-1]);
            end
        end
    endtask

`ifdef WHIRLPOOL_TARGET_CMP_EN
    task automatic test_target();
        int lat;
        target_a = 64'h08B138CC42A66EB3;
        submit_a(512'd0, EMPTY_BLK, 8'h11);
        target_a = 64'd0;
        wait_valid_a(lat);
        checks++;
        if (out_match_a !== 1'b1) begin failures++; $display("FAIL target_equal: out_match=%0b required 1", out_match_a); end
        drain_a();
        target_a = 64'h08B138CC42A66EB2;
        submit_a(512'd0, EMPTY_BLK, 8'h12);
        target_a = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_valid_a(lat);
        checks++;
        if (out_match_a !== 1'b0) begin failures++; $display("FAIL target_below: out_match=%0b required 0", out_match_a); end
        drain_a();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        in_valid_a = 1'b0; abort_a = 1'b0; out_ready_a = 1'b0;
        in_state_a = '0; in_block_a = '0; in_tag_a = '0;
        in_valid_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b0;
        in_state_b = '0; in_block_b = '0; in_tag_b = '0;
`ifdef WHIRLPOOL_TARGET_CMP_EN
        target_a = '0;
        target_b = '1;
`endif
        test_reset();
        test_empty_vector();
        test_backpressure();
        test_abort();
        test_abort_idle();
        test_abort_done();
        test_async_reset();
        test_rounds1();
        test_back_to_back();
`ifdef WHIRLPOOL_TARGET_CMP_EN
        test_target();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/whirlpool_iter_core.md
Name: whirlpool_iter_core

Overview:
Parametrised, handshaked successor to the iterative Whirlpool compression core. It runs one 512-bit Miyaguchi-Preneel compression (midstate + block) by alternating key-schedule and data rounds through one shared instance of the existing process_round function. The round count is configurable, a job tag is carried with each job, and a job can be aborted. It sits between the work dispatcher and the result/nonce checker in the miner datapath.

Parameters:
ROUNDS, 10, number of Whirlpool rounds, legal 1..10; any other value is an elaboration error.
TAG_W, 8, width of the job tag carried from input to output, legal 1..32.

Ports:
clk  input  1  core clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset; clears FSM and outputs immediately.
in_valid  input  1  job offered.
in_ready  output  1  core can accept a job; high only in IDLE.
in_state  input  512  chaining value (midstate); byte 0 is in_state[511:504].
in_block  input  512  message block; same byte order.
in_tag  input  TAG_W  job identifier.
abort  input  1  synchronous cancel of the current job.
out_valid  output  1  hash and tag valid; held until accepted.
out_ready  input  1  downstream accepts the result.
out_hash  output  512  state ^ block ^ final round output, registered.
out_tag  output  TAG_W  tag of the job in out_hash.
busy  output  1  high in KEY, DATA and DONE.

Behaviour:
- Reset (rst low, asynchronous): FSM=IDLE, round counter=0, out_valid=0, out_hash=0, out_tag=0, busy=0, in_ready=1 once rst is released. All internal working registers are cleared.
- States: IDLE, KEY, DATA, DONE.
- IDLE: in_ready=1. On in_valid & ~abort, capture in_state, in_block and in_tag; set K=in_state and D=in_block^in_state; set r=0; go to KEY.
- KEY (one cycle): K <= process_round(K, {RC[r], 448'd0}); go to DATA.
- DATA (one cycle): D <= process_round(D, K_new), where K_new is the K registered in the preceding KEY cycle.
  - If r==ROUNDS-1: out_hash <= state_q ^ block_q ^ D_next, out_tag <= tag_q, out_valid <= 1, go to DONE.
  - Otherwise r <= r+1 and go to KEY.
- RC[0..9] is the standard Whirlpool constant table, 1823C6E887B8014F through CA2DBF07AD5A8333. Index r is 4 bits and never exceeds ROUNDS-1.
- Latency: out_valid rises exactly 2*ROUNDS rising edges after the capture edge (20 for the default).
- Only one process_round instance exists. Its inputs are muxed by the FSM: (K, RC) in KEY, (D, K) in DATA.
- DONE: out_valid=1, and out_hash/out_tag stay stable. On out_ready, clear out_valid and go to IDLE on that edge. in_ready stays 0 in DONE, so there is no same-cycle accept; the next job is captured one cycle later at the earliest.
- abort:
  - In KEY, DATA or DONE: next edge goes to IDLE, out_valid=0, and the result is discarded.
  - In IDLE: abort overrides in_valid, and no capture occurs.
  - abort has priority over out_ready in DONE. The hash is dropped and the handshake is not counted.
- in_valid while not in IDLE is ignored; the input buses need not be held by the source after capture.
- Reset asserted mid-job: immediate return to IDLE, and outputs are cleared regardless of the clock.
- All arithmetic is bitwise XOR on 512 bits; there are no carries. The round counter wraps to 0 on every new capture.

Optional Feature:
WHIRLPOOL_TARGET_CMP_EN
- Defined:
  - Adds input target [63:0], sampled at capture and stored with the job.
  - Adds output out_match (1 bit), registered together with out_hash.
  - out_match = (out_hash[63:0] <= target_q), unsigned compare.
  - out_match resets to 0, is valid only while out_valid=1, and is cleared by abort.
- Not defined: the target and out_match ports do not exist, and no compare logic is built.

Test Plan:
- Empty-message vector:
  - Stimulus: ROUNDS=10, in_state=0, in_block=0x80 followed by 63 zero bytes, in_tag=0x5A.
  - Response: after 20 edges out_valid=1, out_tag=0x5A, out_hash=19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3.
- Back-pressure: hold out_ready=0 for 50 cycles after out_valid. out_hash and out_tag stay stable and in_ready stays 0; one cycle after out_ready=1, in_ready=1.
- Abort:
  - Assert abort in the 7th cycle after capture. Next edge: IDLE, in_ready=1, out_valid stays 0.
  - Then submit the empty-message job. The correct digest appears 20 edges after its capture.
- Async reset: drive rst low mid-DATA, between clock edges. out_valid, busy and out_hash go to 0 immediately; after release, in_ready=1 and a fresh job gives the correct digest.
- Round parameter: ROUNDS=1, random state and block. out_valid appears 2 edges after capture, and out_hash matches a one-round software model; back-to-back jobs accepted every 4 cycles with out_ready tied high.
- WHIRLPOOL_TARGET_CMP_EN: run the empty-message job with target=0x08B138CC42A66EB3, expecting out_match=1. Repeat with target=0x08B138CC42A66EB2, expecting out_match=0.
